// File: rtl/msrv_32_pkg.sv
// Shared encodings for the MSRV32 data-memory path: store sizes, AHB HTRANS values
// and the store-unit FSM states.
package msrv_32_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StAddr = 2'b01,
    StData = 2'b10
  } store_state_e;

endpackage

// File: rtl/msrv_32_store_align.sv
// Pure combinational byte-lane placement, write-mask generation and misalignment
// detection for a store of the given size at the given byte offset.
module msrv_32_store_align
  import msrv_32_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rs2_i,
  input  logic [1:0]  size_i,
  output logic [31:0] data_o,
  output logic [3:0]  mask_o,
  output logic        misaligned_o
);

  always_comb begin
    data_o       = rs2_i;
    mask_o       = 4'b1111;
    misaligned_o = 1'b0;
    unique case (size_i)
      SZ_BYTE: begin
        data_o = {4{rs2_i[7:0]}};
        mask_o = 4'b0001 << addr_lo_i;
      end
      SZ_HALF: begin
        data_o       = {2{rs2_i[15:0]}};
        mask_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        misaligned_o = addr_lo_i[0];
      end
      // SZ_WORD and the reserved 2'b11 encoding both behave as a word store.
      default: begin
        data_o       = rs2_i;
        mask_o       = 4'b1111;
        misaligned_o = (addr_lo_i != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/msrv_32_store_unit.sv
// MSRV32 store unit: aligns store data onto byte lanes and runs a registered
// two-phase AHB-style write, stalling the pipeline while a write is outstanding.
module msrv_32_store_unit
  import msrv_32_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              ms_risc32_mp_clk_in,
  input  logic              ms_risc32_mp_rst_in,
  input  logic              mem_wr_req_in,
  input  logic [ADDR_W-1:0] iadder_in,
  input  logic [DATA_W-1:0] rs2_in,
  input  logic [1:0]        store_size_in,
  input  logic              ahb_ready_in,
  input  logic              ahb_resp_in,
  output logic [ADDR_W-1:0] ms_risc32_mp_dmaddr_out,
  output logic [DATA_W-1:0] ms_risc32_mp_dmdata_out,
  output logic [3:0]        ms_risc32_mp_dmwr_mask_out,
  output logic              ms_risc32_mp_dmwr_req_out,
  output logic [1:0]        ahb_htrans_out,
  output logic              store_busy_out,
  output logic              store_done_out,
  output logic              store_err_out,
  output logic              store_misaligned_out
);

  logic [DATA_W-1:0] al_data;
  logic [3:0]        al_mask;
  logic              al_misaligned;

  msrv_32_store_align u_align (
    .addr_lo_i    (iadder_in[1:0]),
    .rs2_i        (rs2_in),
    .size_i       (store_size_in),
    .data_o       (al_data),
    .mask_o       (al_mask),
    .misaligned_o (al_misaligned)
  );

  store_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [3:0]        mask_q, mask_d;
  logic              wr_req_q, wr_req_d;
  logic [1:0]        htrans_q, htrans_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              misaligned_q, misaligned_d;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    mask_d       = mask_q;
    wr_req_d     = wr_req_q;
    htrans_d     = htrans_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    misaligned_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem_wr_req_in) begin
          if (al_misaligned) begin
            misaligned_d = 1'b1;
          end else begin
            addr_d   = {iadder_in[ADDR_W-1:2], 2'b00};
            data_d   = al_data;
            mask_d   = al_mask;
            wr_req_d = 1'b1;
            htrans_d = HT_NONSEQ;
            state_d  = StAddr;
          end
        end
      end
      StAddr: begin
        if (ahb_ready_in) begin
          htrans_d = HT_IDLE;
          state_d  = StData;
        end
      end
      StData: begin
        if (ahb_ready_in) begin
          // Address and data are left on the bus; only the enables drop.
          mask_d   = 4'b0000;
          wr_req_d = 1'b0;
          done_d   = ~ahb_resp_in;
          err_d    = ahb_resp_in;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ms_risc32_mp_clk_in) begin
    if (ms_risc32_mp_rst_in) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      data_q       <= '0;
      mask_q       <= 4'b0000;
      wr_req_q     <= 1'b0;
      htrans_q     <= HT_IDLE;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      mask_q       <= mask_d;
      wr_req_q     <= wr_req_d;
      htrans_q     <= htrans_d;
      done_q       <= done_d;
      err_q        <= err_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign ms_risc32_mp_dmaddr_out    = addr_q;
  assign ms_risc32_mp_dmdata_out    = data_q;
  assign ms_risc32_mp_dmwr_mask_out = mask_q;
  assign ms_risc32_mp_dmwr_req_out  = wr_req_q;
  assign ahb_htrans_out             = htrans_q;
  assign store_busy_out             = (state_q != StIdle);
  assign store_done_out             = done_q;
  assign store_err_out              = err_q;
  assign store_misaligned_out       = misaligned_q;

endmodule

// File: tb/tb_msrv_32_store_unit.sv
// Self-checking bench for msrv_32_store_unit: directed scenarios plus randomized
// stores checked cycle by cycle against a transaction-level reference model.
module tb_msrv_32_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [31:0] iadder;
  logic [31:0] rs2;
  logic [1:0]  sz;
  logic        ready;
  logic        resp;

  logic [31:0] dmaddr;
  logic [31:0] dmdata;
  logic [3:0]  dmmask;
  logic        dmwr_req;
  logic [1:0]  htrans;
  logic        busy;
  logic        done;
  logic        err;
  logic        mis;

  int checks = 0;
  int errors = 0;

  // Model of the address/data the unit keeps on the bus between transfers.
  logic [31:0] m_addr;
  logic [31:0] m_data;

  // {addr, data, mask, wr_req, htrans, busy, done, err, misaligned}
  logic [74:0] obs;
  assign obs = {dmaddr, dmdata, dmmask, dmwr_req, htrans, busy, done, err, mis};

  always #5 clk = ~clk;

  msrv_32_store_unit dut (
    .ms_risc32_mp_clk_in        (clk),
    .ms_risc32_mp_rst_in        (rst),
    .mem_wr_req_in              (req),
    .iadder_in                  (iadder),
    .rs2_in                     (rs2),
    .store_size_in              (sz),
    .ahb_ready_in               (ready),
    .ahb_resp_in                (resp),
    .ms_risc32_mp_dmaddr_out    (dmaddr),
    .ms_risc32_mp_dmdata_out    (dmdata),
    .ms_risc32_mp_dmwr_mask_out (dmmask),
    .ms_risc32_mp_dmwr_req_out  (dmwr_req),
    .ahb_htrans_out             (htrans),
    .store_busy_out             (busy),
    .store_done_out             (done),
    .store_err_out              (err),
    .store_misaligned_out       (mis)
  );

  // Issue one store from IDLE and check every cycle until the unit is idle again.
  // aw/dw are wait states inserted in the address/data phases; r is the data-phase HRESP.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                          input int aw, input int dw, input logic r, input string tag);
    int          nb;
    logic [31:0] ed;
    logic [3:0]  em;
    logic        emis;
    logic [74:0] exp;
    nb   = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    emis = (int'(a[1:0]) % nb) != 0;
    ed   = (nb == 1) ? {24'b0, d[7:0]} * 32'h0101_0101 :
           (nb == 2) ? {16'b0, d[15:0]} * 32'h0001_0001 : d;
    em   = 4'((1 << nb) - 1);
    em   = em << a[1:0];

    req = 1'b1; iadder = a; rs2 = d; sz = s; ready = 1'($urandom); resp = 1'($urandom);
    @(posedge clk); #1;
    req = 1'b0; iadder = $urandom; rs2 = $urandom; sz = 2'($urandom);

    if (emis) begin
      exp = {m_addr, m_data, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL %s misaligned_pulse: got %h want %h", tag, obs, exp);
      end
      @(posedge clk); #1;
      exp[0] = 1'b0;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL %s misaligned_clear: got %h want %h", tag, obs, exp);
      end
      return;
    end

    m_addr = {a[31:2], 2'b00};
    m_data = ed;
    for (int i = 0; i <= aw; i++) begin
      exp = {m_addr, m_data, em, 1'b1, 2'b10, 1'b1, 3'b000};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL %s addr_phase[%0d]: got %h want %h", tag, i, obs, exp);
      end
      req = 1'($urandom); ready = (i == aw); resp = 1'($urandom);
      @(posedge clk); #1;
    end
    for (int j = 0; j <= dw; j++) begin
      exp = {m_addr, m_data, em, 1'b1, 2'b00, 1'b1, 3'b000};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL %s data_phase[%0d]: got %h want %h", tag, j, obs, exp);
      end
      req = 1'($urandom); ready = (j == dw); resp = (j == dw) ? r : 1'($urandom);
      @(posedge clk); #1;
    end
    req = 1'b0; ready = 1'($urandom); resp = 1'($urandom);
    exp = {m_addr, m_data, 4'b0000, 1'b0, 2'b00, 1'b0, ~r, r, 1'b0};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s complete: got %h want %h", tag, obs, exp);
    end
    @(posedge clk); #1;
    exp[2:1] = 2'b00;
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s pulse_clear: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req = 1'($urandom); iadder = $urandom; rs2 = $urandom; sz = 2'($urandom);
      ready = 1'($urandom); resp = 1'($urandom);
      @(posedge clk); #1;
      checks++;
      if (obs !== 75'd0) begin
        errors++;
        $display("FAIL reset[%0d]: got %h want 0", i, obs);
      end
    end
    rst = 1'b0; req = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  task automatic test_byte();
    do_store(32'h0000_1003, 32'h0000_00A5, 2'b00, 0, 0, 1'b0, "sb_1003");
    do_store(32'h0000_1000, 32'h1234_5678, 2'b00, 0, 0, 1'b0, "sb_1000");
  endtask

  task automatic test_half_word();
    do_store(32'h0000_2002, 32'h1234_BEEF, 2'b01, 0, 0, 1'b0, "sh_2002");
    do_store(32'h0000_2004, 32'hDEAD_BEEF, 2'b10, 0, 0, 1'b0, "sw_2004");
    do_store(32'h0000_2008, 32'hCAFE_F00D, 2'b11, 0, 0, 1'b0, "sz11_2008");
  endtask

  task automatic test_wait_states();
    do_store(32'h0000_3004, 32'h0BAD_CAFE, 2'b10, 2, 3, 1'b0, "sw_wait");
  endtask

  task automatic test_error();
    do_store(32'h0000_4000, 32'h5555_AAAA, 2'b10, 0, 0, 1'b1, "sw_err");
    do_store(32'h0000_4001, 32'h0000_0077, 2'b00, 1, 1, 1'b1, "sb_err_wait");
  endtask

  task automatic test_misaligned();
    do_store(32'h0000_5001, 32'h1111_2222, 2'b01, 0, 0, 1'b0, "sh_5001");
    do_store(32'h0000_5002, 32'h3333_4444, 2'b10, 0, 0, 1'b0, "sw_5002");
    do_store(32'h0000_5003, 32'h3333_4444, 2'b11, 0, 0, 1'b0, "sz11_5003");
  endtask

  task automatic test_reset_mid();
    req = 1'b1; iadder = 32'h0000_6000; rs2 = 32'h6666_7777; sz = 2'b10; ready = 1'b1;
    resp = 1'b0;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    ready = 1'b0; resp = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1 || dmwr_req !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid stalled: got busy=%b wr_req=%b want 1 1", busy, dmwr_req);
    end
    rst = 1'b1; ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (obs !== 75'd0) begin
      errors++;
      $display("FAIL rst_mid reset: got %h want 0", obs);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (obs !== 75'd0) begin
      errors++;
      $display("FAIL rst_mid after: got %h want 0", obs);
    end
    m_addr = '0;
    m_data = '0;
    do_store(32'h0000_7002, 32'h0000_00C3, 2'b00, 0, 0, 1'b0, "sb_after_rst");
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      do_store($urandom, $urandom, 2'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
               ($urandom_range(0, 3) == 0), "rand");
    end
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; iadder = '0; rs2 = '0; sz = 2'b00; ready = 1'b0; resp = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_byte();
    test_half_word();
    test_wait_states();
    test_error();
    test_misaligned();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/msrv_32_store_unit.md
Name: msrv_32_store_unit

Overview:
Data-memory write path of the MSRV32 core, and the write-side counterpart of the load unit. It takes the store address from the immediate adder, rs2 data and store size. It places the data on the correct byte lanes and generates the 4-bit write mask. It then runs a registered two-phase AHB-style write (address phase, then data phase) with wait-state and error-response handling. It sits between the execute stage and the data-memory bus, and asserts a busy stall toward the pipeline while a write is outstanding.

Parameters:
ADDR_W, 32, data-memory address width
DATA_W, 32, data bus width; fixed at 32, with 4 byte lanes

Ports:
ms_risc32_mp_clk_in  input  1  core clock; all state updates on its rising edge
ms_risc32_mp_rst_in  input  1  synchronous reset, active-high
mem_wr_req_in  input  1  store request from execute stage; sampled only in IDLE
iadder_in  input  32  store byte address
rs2_in  input  32  store source data, right-justified
store_size_in  input  2  00 byte, 01 half, 10 word, 11 treated as word
ahb_ready_in  input  1  bus HREADY; 1 completes the current phase
ahb_resp_in  input  1  bus HRESP; 1 means error, sampled when the data phase completes
ms_risc32_mp_dmaddr_out  output  32  word-aligned address {iadder[31:2],2'b00}
ms_risc32_mp_dmdata_out  output  32  lane-aligned write data
ms_risc32_mp_dmwr_mask_out  output  4  byte-lane write enables
ms_risc32_mp_dmwr_req_out  output  1  write transfer active (ADDR or DATA phase)
ahb_htrans_out  output  2  10 NONSEQ in ADDR phase, 00 IDLE otherwise
store_busy_out  output  1  1 whenever state is not IDLE; pipeline must stall
store_done_out  output  1  one-cycle pulse when the data phase completes without error
store_err_out  output  1  one-cycle pulse on bus error
store_misaligned_out  output  1  one-cycle pulse on a misaligned request; no bus transfer is issued

Behaviour:
- Reset (sync, active-high, overrides everything):
  - state to IDLE
  - all outputs 0; htrans 00
  - an in-flight transfer is abandoned with no done or err pulse
- Lane alignment (combinational on inputs, registered on acceptance):
  - byte: data {4{rs2[7:0]}}; mask 0001 shifted left by iadder[1:0]
  - half: data {2{rs2[15:0]}}; mask 0011 if iadder[1]=0, else 1100
  - word or size 11: data rs2; mask 1111
- Misalignment:
  - half with iadder[0]=1, or word with iadder[1:0]!=00
  - no state change; misaligned_out pulses the following cycle; mask stays 0000
- FSM IDLE -> ADDR -> DATA -> IDLE:
  - IDLE: if mem_wr_req_in and aligned, register addr, data and mask, and go to ADDR. In the next cycle wr_req_out=1 and htrans=10.
  - ADDR: hold all outputs stable while ahb_ready_in=0. On ahb_ready_in=1 go to DATA; htrans becomes 00; addr, data, mask and wr_req stay stable.
  - DATA: hold while ahb_ready_in=0. On ahb_ready_in=1:
    - ahb_resp_in=0: pulse done_out the next cycle.
    - ahb_resp_in=1: pulse err_out the next cycle.
    - In both cases go to IDLE, clear mask and wr_req, and keep data/addr as last values.
- Latency: with zero wait states, request to done pulse is 3 cycles; maximum throughput is one store per 3 cycles.
- mem_wr_req_in while busy is ignored. Upstream holds it under stall and it is re-sampled in IDLE.
- ahb_resp_in is ignored outside a completing data phase.
- done_out and err_out are mutually exclusive.

Decomposition:
- Shared package msrv_32_pkg holds:
  - store-size encodings (SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10)
  - HTRANS encodings (HT_IDLE=2'b00, HT_NONSEQ=2'b10)
  - FSM state encodings (IDLE, ADDR, DATA)
- One natural sub-module: msrv_32_store_align, the pure combinational lane/mask/misalign logic, reusable by formal checks against the load unit.

Test Plan:
- SB at 0x1003, rs2=0x000000A5, ready=1 -> ADDR cycle with addr=0x1000, data=0xA5A5A5A5, mask=1000, htrans=10; done pulse 3 cycles after the request.
- SH at 0x2002, rs2=0x1234BEEF -> data=0xBEEFBEEF, mask=1100; SW at 0x2004, rs2=0xDEADBEEF -> data=0xDEADBEEF, mask=1111.
- SW at 0x3004, ready held 0 for 2 cycles in ADDR and 3 in DATA -> all outputs stable throughout; busy=1; done 8 cycles after the request.
- SW at 0x4000, ahb_resp_in=1 when DATA completes -> err_out pulses for 1 cycle; done_out stays 0; state returns to IDLE.
- SH at 0x5001 and SW at 0x5002 -> misaligned_out pulses, wr_req and htrans stay 0, busy stays 0.
- Reset asserted during a stalled DATA phase -> next cycle all outputs 0, IDLE, no done or err; a new SB after reset completes normally.
